// File: rtl/ex_mem_pipe_reg_if.sv
// EX->MEM pipeline-register bus: E-stage inputs, control strobes and M-stage outputs.
// Performance-counter signals exist only when EX_MEM_PERF_CNT_EN is defined.
interface ex_mem_pipe_reg_if #(
  parameter int DATA_W  = 32,
  parameter int REG_W   = 5,
  parameter int INSTR_W = 32,
  parameter int CNT_W   = 16
);
  logic               stall_m;
  logic               flush_m;
  logic               halt_clr;

  logic               valid_e;
  logic               syscall_e;
  logic               regwrite_e;
  logic               memtoreg_e;
  logic               memwrite_e;
  logic [DATA_W-1:0]  alu_out_e;
  logic [DATA_W-1:0]  write_data_e;
  logic [REG_W-1:0]   write_reg_e;
  logic [REG_W-1:0]   rs_e;
  logic [INSTR_W-1:0] instr_e;

  logic               valid_m;
  logic               syscall_m;
  logic               regwrite_m;
  logic               memtoreg_m;
  logic               memwrite_m;
  logic [DATA_W-1:0]  alu_out_m;
  logic [DATA_W-1:0]  write_data_m;
  logic [REG_W-1:0]   write_reg_m;
  logic [REG_W-1:0]   rs_m;
  logic [INSTR_W-1:0] instr_m;

  logic               hz_regwrite_m;
  logic               hz_memtoreg_m;
  logic               hz_memwrite_m;
  logic               halted;

`ifdef EX_MEM_PERF_CNT_EN
  logic [CNT_W-1:0]   stall_cnt;
  logic [CNT_W-1:0]   bubble_cnt;

  modport master (
    output stall_m, flush_m, halt_clr,
    output valid_e, syscall_e, regwrite_e, memtoreg_e, memwrite_e,
    output alu_out_e, write_data_e, write_reg_e, rs_e, instr_e,
    input  valid_m, syscall_m, regwrite_m, memtoreg_m, memwrite_m,
    input  alu_out_m, write_data_m, write_reg_m, rs_m, instr_m,
    input  hz_regwrite_m, hz_memtoreg_m, hz_memwrite_m, halted,
    input  stall_cnt, bubble_cnt
  );

  modport slave (
    input  stall_m, flush_m, halt_clr,
    input  valid_e, syscall_e, regwrite_e, memtoreg_e, memwrite_e,
    input  alu_out_e, write_data_e, write_reg_e, rs_e, instr_e,
    output valid_m, syscall_m, regwrite_m, memtoreg_m, memwrite_m,
    output alu_out_m, write_data_m, write_reg_m, rs_m, instr_m,
    output hz_regwrite_m, hz_memtoreg_m, hz_memwrite_m, halted,
    output stall_cnt, bubble_cnt
  );
`else
  logic unused_cnt_w;
  assign unused_cnt_w = ^CNT_W;

  modport master (
    output stall_m, flush_m, halt_clr,
    output valid_e, syscall_e, regwrite_e, memtoreg_e, memwrite_e,
    output alu_out_e, write_data_e, write_reg_e, rs_e, instr_e,
    input  valid_m, syscall_m, regwrite_m, memtoreg_m, memwrite_m,
    input  alu_out_m, write_data_m, write_reg_m, rs_m, instr_m,
    input  hz_regwrite_m, hz_memtoreg_m, hz_memwrite_m, halted
  );

  modport slave (
    input  stall_m, flush_m, halt_clr,
    input  valid_e, syscall_e, regwrite_e, memtoreg_e, memwrite_e,
    input  alu_out_e, write_data_e, write_reg_e, rs_e, instr_e,
    output valid_m, syscall_m, regwrite_m, memtoreg_m, memwrite_m,
    output alu_out_m, write_data_m, write_reg_m, rs_m, instr_m,
    output hz_regwrite_m, hz_memtoreg_m, hz_memwrite_m, halted
  );
`endif
endinterface

// File: rtl/ex_mem_pipe_reg.sv
// EX->MEM pipeline register with stall/flush, valid-gated hazard copies and a syscall halt FSM.
// Define EX_MEM_PERF_CNT_EN to add saturating stall/bubble performance counters.
module ex_mem_pipe_reg #(
  parameter int DATA_W  = 32,
  parameter int REG_W   = 5,
  parameter int INSTR_W = 32,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  ex_mem_pipe_reg_if.slave  bus
);

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  state_t             state_reg, state_next;
  logic               load_bubble, load_instr;

  logic               valid_reg, syscall_reg, regwrite_reg, memtoreg_reg, memwrite_reg;
  logic               hz_regwrite_reg, hz_memtoreg_reg, hz_memwrite_reg;
  logic [DATA_W-1:0]  alu_out_reg, write_data_reg;
  logic [REG_W-1:0]   write_reg_reg, rs_reg;
  logic [INSTR_W-1:0] instr_reg;

  // Flush always wins over stall and keeps the current state; halt_clr is honoured
  // only on an ordinary (non-flush, non-stall) edge while HALTED.
  always_comb begin
    state_next  = state_reg;
    load_bubble = 1'b0;
    load_instr  = 1'b0;
    if (bus.flush_m) begin
      load_bubble = 1'b1;
    end else if (!bus.stall_m) begin
      if (state_reg == HALTED) begin
        load_bubble = 1'b1;
        if (bus.halt_clr) begin
          state_next = RUN;
        end
      end else begin
        load_instr = 1'b1;
        if (bus.valid_e && bus.syscall_e) begin
          state_next = HALTED;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg       <= RUN;
      valid_reg       <= 1'b0;
      syscall_reg     <= 1'b0;
      regwrite_reg    <= 1'b0;
      memtoreg_reg    <= 1'b0;
      memwrite_reg    <= 1'b0;
      hz_regwrite_reg <= 1'b0;
      hz_memtoreg_reg <= 1'b0;
      hz_memwrite_reg <= 1'b0;
      alu_out_reg     <= '0;
      write_data_reg  <= '0;
      write_reg_reg   <= '0;
      rs_reg          <= '0;
      instr_reg       <= '0;
    end else begin
      state_reg <= state_next;
      if (load_bubble) begin
        valid_reg       <= 1'b0;
        syscall_reg     <= 1'b0;
        regwrite_reg    <= 1'b0;
        memtoreg_reg    <= 1'b0;
        memwrite_reg    <= 1'b0;
        hz_regwrite_reg <= 1'b0;
        hz_memtoreg_reg <= 1'b0;
        hz_memwrite_reg <= 1'b0;
        alu_out_reg     <= '0;
        write_data_reg  <= '0;
        write_reg_reg   <= '0;
        rs_reg          <= '0;
        instr_reg       <= '0;
      end else if (load_instr) begin
        valid_reg       <= bus.valid_e;
        syscall_reg     <= bus.syscall_e;
        regwrite_reg    <= bus.regwrite_e;
        memtoreg_reg    <= bus.memtoreg_e;
        memwrite_reg    <= bus.memwrite_e;
        // Hazard copies are pre-gated so the hazard unit never sees an invalid slot.
        hz_regwrite_reg <= bus.regwrite_e & bus.valid_e;
        hz_memtoreg_reg <= bus.memtoreg_e & bus.valid_e;
        hz_memwrite_reg <= bus.memwrite_e & bus.valid_e;
        alu_out_reg     <= bus.alu_out_e;
        write_data_reg  <= bus.write_data_e;
        write_reg_reg   <= bus.write_reg_e;
        rs_reg          <= bus.rs_e;
        instr_reg       <= bus.instr_e;
      end
    end
  end

  assign bus.valid_m       = valid_reg;
  assign bus.syscall_m     = syscall_reg;
  assign bus.regwrite_m    = regwrite_reg;
  assign bus.memtoreg_m    = memtoreg_reg;
  assign bus.memwrite_m    = memwrite_reg;
  assign bus.hz_regwrite_m = hz_regwrite_reg;
  assign bus.hz_memtoreg_m = hz_memtoreg_reg;
  assign bus.hz_memwrite_m = hz_memwrite_reg;
  assign bus.alu_out_m     = alu_out_reg;
  assign bus.write_data_m  = write_data_reg;
  assign bus.write_reg_m   = write_reg_reg;
  assign bus.rs_m          = rs_reg;
  assign bus.instr_m       = instr_reg;
  assign bus.halted        = (state_reg == HALTED);

`ifdef EX_MEM_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] stall_cnt_reg, bubble_cnt_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_reg  <= '0;
      bubble_cnt_reg <= '0;
    end else begin
      if (bus.stall_m && !bus.flush_m && (stall_cnt_reg != CNT_MAX)) begin
        stall_cnt_reg <= stall_cnt_reg + 1'b1;
      end
      if (load_bubble && (bubble_cnt_reg != CNT_MAX)) begin
        bubble_cnt_reg <= bubble_cnt_reg + 1'b1;
      end
    end
  end

  assign bus.stall_cnt  = stall_cnt_reg;
  assign bus.bubble_cnt = bubble_cnt_reg;
`else
  logic unused_cnt_w;
  assign unused_cnt_w = ^CNT_W;
`endif

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Directed self-checking bench for ex_mem_pipe_reg; counter checks run when EX_MEM_PERF_CNT_EN is defined.
module tb_ex_mem_pipe_reg;

  localparam int DATA_W  = 32;
  localparam int REG_W   = 5;
  localparam int INSTR_W = 32;
  localparam int CNT_W   = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  ex_mem_pipe_reg_if #(
    .DATA_W(DATA_W), .REG_W(REG_W), .INSTR_W(INSTR_W), .CNT_W(CNT_W)
  ) bus ();

  ex_mem_pipe_reg #(
    .DATA_W(DATA_W), .REG_W(REG_W), .INSTR_W(INSTR_W), .CNT_W(CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_all(input logic v);
    bus.stall_m      = v;
    bus.flush_m      = v;
    bus.halt_clr     = v;
    bus.valid_e      = v;
    bus.syscall_e    = v;
    bus.regwrite_e   = v;
    bus.memtoreg_e   = v;
    bus.memwrite_e   = v;
    bus.alu_out_e    = {DATA_W{v}};
    bus.write_data_e = {DATA_W{v}};
    bus.write_reg_e  = {REG_W{v}};
    bus.rs_e         = {REG_W{v}};
    bus.instr_e      = {INSTR_W{v}};
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".valid_m"}, bus.valid_m, 0);
    check({tag, ".syscall_m"}, bus.syscall_m, 0);
    check({tag, ".regwrite_m"}, bus.regwrite_m, 0);
    check({tag, ".memtoreg_m"}, bus.memtoreg_m, 0);
    check({tag, ".memwrite_m"}, bus.memwrite_m, 0);
    check({tag, ".alu_out_m"}, bus.alu_out_m, 0);
    check({tag, ".write_data_m"}, bus.write_data_m, 0);
    check({tag, ".write_reg_m"}, bus.write_reg_m, 0);
    check({tag, ".rs_m"}, bus.rs_m, 0);
    check({tag, ".instr_m"}, bus.instr_m, 0);
    check({tag, ".hz_regwrite_m"}, bus.hz_regwrite_m, 0);
    check({tag, ".hz_memtoreg_m"}, bus.hz_memtoreg_m, 0);
    check({tag, ".hz_memwrite_m"}, bus.hz_memwrite_m, 0);
    check({tag, ".halted"}, bus.halted, 0);
`ifdef EX_MEM_PERF_CNT_EN
    check({tag, ".stall_cnt"}, bus.stall_cnt, 0);
    check({tag, ".bubble_cnt"}, bus.bubble_cnt, 0);
`endif
  endtask

  initial begin
    // Reset with every input high
    rst_n = 1'b0;
    drive_all(1'b1);
    tick();
    tick();
    check_all_zero("reset");
    $display("[TB] reset with all inputs high: outputs cleared");

    // First load after reset
    rst_n = 1'b1;
    drive_all(1'b0);
    bus.alu_out_e   = 32'h0000_1234;
    bus.write_reg_e = 5'd5;
    bus.regwrite_e  = 1'b1;
    bus.valid_e     = 1'b1;
    tick();
    check("load.alu_out_m", bus.alu_out_m, 32'h1234);
    check("load.write_reg_m", bus.write_reg_m, 5);
    check("load.hz_regwrite_m", bus.hz_regwrite_m, 1);
    check("load.valid_m", bus.valid_m, 1);
    $display("[TB] load alu=0x1234 wr=5: alu_out_m=0x%0h write_reg_m=%0d", bus.alu_out_m, bus.write_reg_m);

    // Stall holds, then stall+flush loads a bubble
    drive_all(1'b0);
    bus.valid_e    = 1'b1;
    bus.memtoreg_e = 1'b1;
    bus.regwrite_e = 1'b1;
    bus.rs_e       = 5'd1;
    bus.instr_e    = 32'h8C22_0004;
    tick();
    check("lw.instr_m", bus.instr_m, 32'h8C22_0004);
    check("lw.hz_memtoreg_m", bus.hz_memtoreg_m, 1);
    check("lw.rs_m", bus.rs_m, 1);
    $display("[TB] load lw: instr_m=0x%0h", bus.instr_m);
    bus.stall_m = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.instr_e = 32'hDEAD_0000 + i;
      tick();
      check("stall.instr_m", bus.instr_m, 32'h8C22_0004);
      check("stall.valid_m", bus.valid_m, 1);
      $display("[TB] stall edge %0d: instr_m=0x%0h", i, bus.instr_m);
    end
    bus.flush_m = 1'b1;
    tick();
    check("flush.valid_m", bus.valid_m, 0);
    check("flush.instr_m", bus.instr_m, 0);
    check("flush.hz_memtoreg_m", bus.hz_memtoreg_m, 0);
`ifdef EX_MEM_PERF_CNT_EN
    check("flush.stall_cnt", bus.stall_cnt, 3);
    check("flush.bubble_cnt", bus.bubble_cnt, 1);
`endif
    $display("[TB] stall+flush: valid_m=%0b instr_m=0x%0h", bus.valid_m, bus.instr_m);

    // Hazard copies gated by valid
    drive_all(1'b0);
    bus.regwrite_e = 1'b1;
    bus.memwrite_e = 1'b1;
    tick();
    check("gate.regwrite_m", bus.regwrite_m, 1);
    check("gate.memwrite_m", bus.memwrite_m, 1);
    check("gate.hz_regwrite_m", bus.hz_regwrite_m, 0);
    check("gate.hz_memwrite_m", bus.hz_memwrite_m, 0);
    $display("[TB] invalid slot: regwrite_m=%0b hz_regwrite_m=%0b", bus.regwrite_m, bus.hz_regwrite_m);

    // halt_clr in RUN is ignored and a valid syscall_e=0 load is normal
    drive_all(1'b0);
    bus.halt_clr   = 1'b1;
    bus.valid_e    = 1'b1;
    bus.memwrite_e = 1'b1;
    bus.instr_e    = 32'hAC01_0008;
    tick();
    check("clr_run.halted", bus.halted, 0);
    check("clr_run.instr_m", bus.instr_m, 32'hAC01_0008);
    check("clr_run.hz_memwrite_m", bus.hz_memwrite_m, 1);
    $display("[TB] halt_clr in RUN: halted=%0b instr_m=0x%0h", bus.halted, bus.instr_m);

    // A syscall with valid_e=0 does not halt
    drive_all(1'b0);
    bus.syscall_e = 1'b1;
    bus.instr_e   = 32'h0000_000C;
    tick();
    check("sys_inv.halted", bus.halted, 0);
    $display("[TB] invalid syscall: halted=%0b", bus.halted);

    // Syscall halt, bubbles while halted, release
    drive_all(1'b0);
    bus.valid_e   = 1'b1;
    bus.syscall_e = 1'b1;
    bus.instr_e   = 32'h0000_000C;
    tick();
    check("sys.syscall_m", bus.syscall_m, 1);
    check("sys.halted", bus.halted, 1);
    check("sys.instr_m", bus.instr_m, 32'h0000_000C);
    $display("[TB] syscall: syscall_m=%0b halted=%0b", bus.syscall_m, bus.halted);
    bus.syscall_e  = 1'b0;
    bus.regwrite_e = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.instr_e = 32'h2000_0100 + i;
      tick();
      check("halted.valid_m", bus.valid_m, 0);
      check("halted.hz_regwrite_m", bus.hz_regwrite_m, 0);
      check("halted.halted", bus.halted, 1);
      $display("[TB] halted edge %0d: valid_m=%0b", i, bus.valid_m);
    end
    bus.halt_clr = 1'b1;
    tick();
    check("clr.halted", bus.halted, 0);
    check("clr.valid_m", bus.valid_m, 0);
    $display("[TB] halt_clr: halted=%0b valid_m=%0b", bus.halted, bus.valid_m);
    bus.halt_clr = 1'b0;
    bus.instr_e  = 32'h2000_0020;
    tick();
    check("resume.valid_m", bus.valid_m, 1);
    check("resume.instr_m", bus.instr_m, 32'h2000_0020);
    $display("[TB] resume: valid_m=%0b instr_m=0x%0h", bus.valid_m, bus.instr_m);

    // Reset mid-halt
    drive_all(1'b0);
    bus.valid_e   = 1'b1;
    bus.syscall_e = 1'b1;
    bus.instr_e   = 32'h0000_000C;
    tick();
    check("rh.enter_halted", bus.halted, 1);
    rst_n = 1'b0;
    tick();
    check_all_zero("rh");
    $display("[TB] reset while halted: halted=%0b syscall_m=%0b", bus.halted, bus.syscall_m);
    rst_n = 1'b1;
    drive_all(1'b0);
    bus.valid_e      = 1'b1;
    bus.write_data_e = 32'hCAFE_F00D;
    bus.instr_e      = 32'h0000_0044;
    tick();
    check("rh.valid_m", bus.valid_m, 1);
    check("rh.instr_m", bus.instr_m, 32'h44);
    check("rh.write_data_m", bus.write_data_m, 32'hCAFE_F00D);
    check("rh.halted", bus.halted, 0);
    $display("[TB] post-reset load: instr_m=0x%0h", bus.instr_m);

`ifdef EX_MEM_PERF_CNT_EN
    // Stall counter saturates at 15 with CNT_W=4
    bus.stall_m = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      check("sat.stall_cnt", bus.stall_cnt, (i > 15) ? 15 : i);
      $display("[TB] saturation edge %0d: stall_cnt=%0d", i, bus.stall_cnt);
    end
    check("sat.instr_m", bus.instr_m, 32'h44);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
